// File: rtl/ex_stage_pkg.sv
// Shared opcode/result-class encodings, divider width and divider FSM states
// for the execute stage.
package ex_stage_pkg;

  localparam int unsigned DIV_W = 32;

  localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v,
                                                 input logic is_signed);
    return (is_signed && v[DIV_W-1]) ? ((~v) + DIV_W'(1)) : v;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Multi-cycle restoring radix-2 divider (module ex_div): one quotient bit per
// cycle, signed operands handled as magnitudes with sign fix-up on output.
module ex_div
  import ex_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [DIV_W-1:0]   opdata1_i,
  input  logic [DIV_W-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*DIV_W-1:0] result_o,
  output logic               ready_o
);

  div_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [DIV_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             negq_q, negq_d, negr_q, negr_d;
  logic [DIV_W:0]   partial, diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the remainder
    partial = {rem_q, quo_q[DIV_W-1]};
    diff    = partial - {1'b0, dvs_q};
    unique case (state_q)
      DIV_FREE: begin
        if (start_i) begin
          negq_d  = signed_div_i && (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
          negr_d  = signed_div_i && opdata1_i[DIV_W-1];
          quo_d   = magnitude(opdata1_i, signed_div_i);
          dvs_d   = magnitude(opdata2_i, signed_div_i);
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
        end
      end
      DIV_BY_ZERO: begin
        quo_d   = '0;
        rem_d   = '0;
        negq_d  = 1'b0;
        negr_d  = 1'b0;
        state_d = DIV_END;
      end
      DIV_ON: begin
        rem_d = diff[DIV_W] ? partial[DIV_W-1:0] : diff[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], ~diff[DIV_W]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_W - 1)) state_d = DIV_END;
      end
      DIV_END: state_d = DIV_FREE;
      default: state_d = DIV_FREE;
    endcase
    if (annul_i) state_d = DIV_FREE;
  end

  assign ready_o  = (state_q == DIV_END) && !annul_i;
  assign result_o = ready_o ? {(negr_q ? ((~rem_q) + DIV_W'(1)) : rem_q),
                               (negq_q ? ((~quo_q) + DIV_W'(1)) : quo_q)}
                            : '0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arith ALU plus optional multi-cycle
// DIV/DIVU unit, present only when EX_DIV_EN is defined.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        annul_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  logic [31:0] logic_res, shift_res, arith_res, alu_res;

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    unique case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP:  shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'b0, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {31'b0, (reg1_i < reg2_i)};
      default:     ;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (alusel_i)
      RES_LOGIC: alu_res = logic_res;
      RES_SHIFT: alu_res = shift_res;
      RES_ARITH: alu_res = arith_res;
      default:   alu_res = '0;
    endcase
  end

  assign wd_o    = rst ? '0 : wd_i;
  assign wreg_o  = !rst && wreg_i;
  assign wdata_o = rst ? '0 : alu_res;

`ifdef EX_DIV_EN
  logic        is_div, div_ready;
  logic [63:0] div_result;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  ex_div u_div (
    .clk          (clk),
    .rst          (rst),
    .start_i      (is_div),
    .signed_div_i (aluop_i == EXE_DIV_OP),
    .opdata1_i    (reg1_i),
    .opdata2_i    (reg2_i),
    .annul_i      (annul_i),
    .result_o     (div_result),
    .ready_o      (div_ready)
  );

  assign stallreq_o = !rst && is_div && !div_ready && !annul_i;
  assign whilo_o    = !rst && is_div && div_ready;
  assign hi_o       = whilo_o ? div_result[63:32] : '0;
  assign lo_o       = whilo_o ? div_result[31:0]  : '0;
`else
  logic unused_nodiv;
  assign unused_nodiv = clk ^ annul_i;
  assign stallreq_o   = 1'b0;
  assign whilo_o      = 1'b0;
  assign hi_o         = '0;
  assign lo_o         = '0;
`endif

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port aluop_i  input  8  operation code from ID/EX register.
REQ-004 SHALL have port alusel_i  input  3  result class (NOP/LOGIC/SHIFT/ARITH/MOVE).
REQ-005 SHALL have port reg1_i, reg2_i  input  32 each  source operands, already forwarded.
REQ-006 SHALL have port wd_i  input  5  destination register address.
REQ-007 SHALL have port wreg_i  input  1  destination write enable.
REQ-008 SHALL have port annul_i  input  1  pipeline flush, cancels any in-flight divide.
REQ-009 SHALL have port wd_o  output  5 and wreg_o  output  1  pass-through of wd_i/wreg_i, also fed back to ID for forwarding.
REQ-010 SHALL have port wdata_o  output  32  GPR result, also fed back to ID for forwarding.
REQ-011 SHALL have port whilo_o  output  1, hi_o  output  32, lo_o  output  32  HI/LO write request and data.
REQ-012 SHALL have port stallreq_o  output  1  requests pipeline hold while a divide is in progress.

Function
REQ-013 SHALL compute LOGIC ops OR/AND/XOR/NOR and LUI-style OR combinationally in the same cycle.
REQ-014 SHALL compute SHIFT ops SLL/SRL/SRA using reg1_i[4:0] as shift amount and reg2_i as data; SRA sign-fills.
REQ-015 SHALL compute ADDU/SUBU modulo 2^32, SLT signed compare, SLTU unsigned compare, result 0 or 1.
REQ-016 SHALL select wdata_o by alusel_i; NOP class or unknown aluop_i SHALL give wdata_o=0 and wreg_o=wreg_i.
REQ-017 SHALL drive whilo_o=1 only in the cycle a DIV/DIVU result is ready; whilo_o=0 for all other ops.
REQ-018 Divider FSM SHALL have states FREE, BY_ZERO, ON, END.
REQ-019 FREE: on DIV/DIVU with annul_i=0 -> BY_ZERO if reg2_i=0, else ON with iteration counter cleared.
REQ-020 ON: one restoring radix-2 iteration per cycle, 32 iterations, then -> END.
REQ-021 BY_ZERO -> END next cycle, quotient=0, remainder=0.
REQ-022 END: result valid for one cycle, stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder; -> FREE next cycle unconditionally.
REQ-023 stallreq_o SHALL be 1 whenever aluop_i is DIV/DIVU and FSM is not in END; 0 otherwise.
REQ-024 Latency: op presented cycle N -> result in END at cycle N+33 (nonzero divisor) or N+2 (zero divisor).
REQ-025 DIV SHALL divide magnitudes; quotient negated if operand signs differ; remainder takes dividend sign.
REQ-026 annul_i=1 in any state SHALL force FREE next cycle, stallreq_o=0 and whilo_o=0 in that cycle.
REQ-027 A DIV following a DIV back-to-back SHALL start from FREE the cycle after END.

Reset
REQ-028 On rst=1 at clock edge, FSM SHALL enter FREE with counter and dividend/remainder registers cleared.
REQ-029 While rst=1, all outputs SHALL be 0, including stallreq_o and whilo_o.
REQ-030 rst during ON SHALL discard the partial result; no whilo_o pulse occurs.

Configuration
REQ-031 Macro EX_DIV_EN defined: divider FSM and DIV/DIVU support present per REQ-017..027.
REQ-032 EX_DIV_EN undefined: no divider logic; DIV/DIVU behave as NOP, stallreq_o tied 0, whilo_o tied 0.

Structure
REQ-033 aluop/alusel codes, FSM state encodings and divider width SHALL live in the shared defines file.
REQ-034 Divider SHALL be a sub-module ex_div (start, signed, opdata1, opdata2, annul -> result[63:0], ready).

Verification
REQ-035 ORI-class OR, reg1=0x0000_1100, reg2=0x0000_0020 -> wdata_o=0x0000_1120 same cycle, stallreq_o=0.
REQ-036 SRA reg1=4, reg2=0x8000_0000 -> wdata_o=0xF800_0000.
REQ-037 DIVU 100/7 -> stallreq_o high cycles N..N+32, cycle N+33 lo_o=14, hi_o=2, whilo_o=1.
REQ-038 DIV -7/2 -> lo_o=0xFFFF_FFFD, hi_o=0xFFFF_FFFF.
REQ-039 DIV 5/0 -> cycle N+2 lo_o=0, hi_o=0, whilo_o=1.
REQ-040 DIVU 100/7 with annul_i pulse at cycle N+10 -> FSM FREE at N+11, no whilo_o pulse.
